// File: rtl/sd_sinc3_decim_if.sv
// Stream bundle for the sinc3 decimator: bitstream input side and decimated sample output side.
interface sd_sinc3_decim_if #(
    parameter int OUT_WIDTH = 8
);
    logic                 en;
    logic                 sd;
    logic [OUT_WIDTH-1:0] data;
    logic                 valid;

    modport master (output en, output sd, input data, input valid);
    modport slave  (input en, input sd, output data, output valid);
endinterface

// File: rtl/sd_sinc3_decim.sv
// Third-order CIC (sinc3) decimator: 1-bit sigma-delta stream in, saturated unsigned samples out.
module sd_sinc3_decim #(
    parameter int DEC_LOG2  = 5,
    parameter int OUT_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sd_sinc3_decim_if.slave     bus
);
    localparam int W  = 3*DEC_LOG2 + 1;
    localparam int FW = 3*DEC_LOG2;

    logic [W-1:0]          integ_reg [3];
    logic [W-1:0]          integ_in  [3];
    logic [W-1:0]          dly_reg   [3];
    logic [W-1:0]          comb_in   [3];
    logic [W-1:0]          comb_out  [3];
    logic [W-1:0]          x_reg;
    logic [W-1:0]          c3_reg;
    logic [DEC_LOG2-1:0]   dec_cnt_reg;
    logic [1:0]            warm_reg;
    logic                  comb_go_reg;
    logic                  emit_reg;
    logic                  out_go_reg;
    logic                  valid_reg;
    logic [OUT_WIDTH-1:0]  data_reg;
    logic                  strobe;
    logic [FW-1:0]         sat;

    // Integrator chain: each stage accumulates the previous stage's registered value.
    assign integ_in[0] = {{(W-1){1'b0}}, bus.sd};
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_integ_in
            assign integ_in[gi] = integ_reg[gi-1];
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_comb
            assign comb_out[gi] = comb_in[gi] - dly_reg[gi];
        end
        for (genvar gi = 1; gi < 3; gi++) begin : g_comb_in
            assign comb_in[gi] = comb_out[gi-1];
        end
    endgenerate
    assign comb_in[0] = x_reg;

    assign strobe = bus.en & (&dec_cnt_reg);

    // Full-scale input lands exactly on 2^FW (MSB set); clamp it to all-ones.
    assign sat = c3_reg[W-1] ? {FW{1'b1}} : c3_reg[FW-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 3; i++) begin
                integ_reg[i] <= '0;
                dly_reg[i]   <= '0;
            end
            x_reg       <= '0;
            c3_reg      <= '0;
            dec_cnt_reg <= '0;
            warm_reg    <= '0;
            comb_go_reg <= 1'b0;
            emit_reg    <= 1'b0;
            out_go_reg  <= 1'b0;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
        end else begin
            if (bus.en) begin
                for (int i = 0; i < 3; i++) begin
                    integ_reg[i] <= integ_reg[i] + integ_in[i];
                end
                dec_cnt_reg <= dec_cnt_reg + 1'b1;
            end

            if (strobe) begin
                x_reg <= integ_reg[2];
                if (warm_reg != 2'd2) begin
                    warm_reg <= warm_reg + 2'd1;
                end
            end
            comb_go_reg <= strobe;
            emit_reg    <= strobe && (warm_reg == 2'd2);

            // Comb stage runs the cycle after a strobe, independent of the enable.
            if (comb_go_reg) begin
                for (int i = 0; i < 3; i++) begin
                    dly_reg[i] <= comb_in[i];
                end
                c3_reg <= comb_out[2];
            end
            out_go_reg <= comb_go_reg && emit_reg;

            valid_reg <= out_go_reg;
            if (out_go_reg) begin
                data_reg <= sat[FW-1 -: OUT_WIDTH];
            end
        end
    end

    assign bus.data  = data_reg;
    assign bus.valid = valid_reg;
endmodule

// File: tb/tb_sd_sinc3_decim.sv
// Directed bench for sd_sinc3_decim at DEC_LOG2=5, OUT_WIDTH=8 (R=32).
module tb_sd_sinc3_decim;
    logic clk = 1'b0;
    logic rst;
    int   assertions = 0;
    int   failures   = 0;
    int   mode       = 0;     // 0 const sd, 1 alternating sd, 2 toggled en, 3 first-order modulator
    logic sd_const   = 1'b0;
    logic [7:0] level = 8'd0;
    logic [7:0] acc   = 8'd0;

    always #5 clk = ~clk;

    sd_sinc3_decim_if #(.OUT_WIDTH(8)) bus ();

    sd_sinc3_decim #(.DEC_LOG2(5), .OUT_WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic mod_step();
        logic [8:0] s;
        s = {1'b0, acc} + {1'b0, level};
        bus.sd = s[8];
        acc    = s[7:0];
    endtask

    task automatic init_inputs();
        bus.en = 1'b1;
        case (mode)
            0: bus.sd = sd_const;
            1: bus.sd = 1'b1;
            2: bus.sd = 1'b1;
            default: mod_step();
        endcase
    endtask

    // One clock: outputs are valid to sample on return; inputs advance for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0: begin bus.sd = sd_const; bus.en = 1'b1; end
            1: begin bus.sd = ~bus.sd; bus.en = 1'b1; end
            2: begin bus.en = ~bus.en; bus.sd = 1'b1; end
            default: begin bus.en = 1'b1; mod_step(); end
        endcase
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.valid && n < max);
        if (!bus.valid) n = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.en = 1'b0;
        bus.sd = 1'b0;
        acc = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        init_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.sd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        assertions++;
        if (bus.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00", bus.data);
        end
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0", bus.valid);
        end
        $display("reset: data=%h valid=%b", bus.data, bus.valid);
    endtask

    task automatic test_zero();
        int n;
        mode = 0; sd_const = 1'b0;
        apply_reset();
        wait_valid(200, n);
        assertions++;
        if (n !== 98) begin
            failures++;
            $display("FAIL zero_first_latency: got %0d clocks expected 98", n);
        end
        for (int k = 0; k < 3; k++) begin
            assertions++;
            if (bus.data !== 8'h00) begin
                failures++;
                $display("FAIL zero_data[%0d]: got %h expected 00", k, bus.data);
            end
            wait_valid(100, n);
            assertions++;
            if (n !== 32) begin
                failures++;
                $display("FAIL zero_spacing[%0d]: got %0d clocks expected 32", k, n);
            end
            $display("zero: sample %0d data=%h spacing=%0d", k, bus.data, n);
        end
    endtask

    task automatic test_full_scale();
        int n;
        mode = 0; sd_const = 1'b1;
        apply_reset();
        wait_valid(200, n);
        for (int k = 2; k <= 6; k++) begin
            wait_valid(100, n);
            if (k >= 4) begin
                assertions++;
                if (bus.data !== 8'hFF) begin
                    failures++;
                    $display("FAIL full_data[%0d]: got %h expected ff", k, bus.data);
                end
                assertions++;
                if (dut.c3_reg !== 16'h8000) begin
                    failures++;
                    $display("FAIL full_c3[%0d]: got %0d expected 32768", k, dut.c3_reg);
                end
            end
            $display("full: sample %0d data=%h c3=%0d", k, bus.data, dut.c3_reg);
        end
    endtask

    task automatic test_alternating();
        int n;
        mode = 1;
        apply_reset();
        wait_valid(200, n);
        for (int k = 2; k <= 6; k++) begin
            wait_valid(100, n);
            if (k >= 4) begin
                assertions++;
                if (bus.data !== 8'h80) begin
                    failures++;
                    $display("FAIL alt_data[%0d]: got %h expected 80", k, bus.data);
                end
                assertions++;
                if (dut.c3_reg !== 16'h4000) begin
                    failures++;
                    $display("FAIL alt_c3[%0d]: got %0d expected 16384", k, dut.c3_reg);
                end
            end
            $display("alternating: sample %0d data=%h c3=%0d", k, bus.data, dut.c3_reg);
        end
    endtask

    task automatic test_en_toggle();
        int n;
        mode = 2;
        apply_reset();
        wait_valid(400, n);
        for (int k = 2; k <= 5; k++) begin
            wait_valid(200, n);
            assertions++;
            if (n !== 64) begin
                failures++;
                $display("FAIL en_spacing[%0d]: got %0d clocks expected 64", k, n);
            end
            if (k >= 4) begin
                assertions++;
                if (bus.data !== 8'hFF) begin
                    failures++;
                    $display("FAIL en_data[%0d]: got %h expected ff", k, bus.data);
                end
            end
            $display("en_toggle: sample %0d data=%h spacing=%0d", k, bus.data, n);
        end
    endtask

    task automatic test_loopback();
        int n;
        int diff;
        logic [7:0] levels [4];
        levels[0] = 8'h00; levels[1] = 8'h40; levels[2] = 8'h80; levels[3] = 8'hC0;
        mode = 3; level = levels[0];
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            level = levels[k];
            repeat (1000) tick();
            wait_valid(100, n);
            diff = int'(bus.data) - int'(levels[k]);
            assertions++;
            if (n < 0 || diff > 1 || diff < -1) begin
                failures++;
                $display("FAIL loopback[%0d]: got %h (wait %0d) expected %h +-1", k, bus.data, n, levels[k]);
            end
            $display("loopback: level %h data=%h", levels[k], bus.data);
        end
    endtask

    task automatic test_reset_midwindow();
        int n;
        mode = 0; sd_const = 1'b1;
        apply_reset();
        repeat (5) wait_valid(200, n);
        assertions++;
        if (bus.data !== 8'hFF) begin
            failures++;
            $display("FAIL mid_pre_data: got %h expected ff", bus.data);
        end
        // valid fires two clocks after the strobe, so the counter is 2 here; 15 more clocks reach 17.
        repeat (15) tick();
        rst = 1'b1;
        #1;
        assertions++;
        if (bus.data !== 8'h00 || bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_clear: got data=%h valid=%b expected 00/0", bus.data, bus.valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        init_inputs();
        wait_valid(200, n);
        assertions++;
        if (n !== 98) begin
            failures++;
            $display("FAIL mid_restart_latency: got %0d clocks expected 98", n);
        end
        $display("reset_midwindow: restart latency=%0d", n);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_full_scale();
        test_alternating();
        test_en_toggle();
        test_loopback();
        test_reset_midwindow();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sd_sinc3_decim.md
Name: sd_sinc3_decim

Overview:
- Third-order CIC (sinc3) decimation filter that turns a 1-bit sigma-delta bitstream into unsigned multi-bit samples.
- It is the receive/decode counterpart of mod2_dac. It demodulates mod2_dac output in loopback tests.
- It also serves as the digital back end for external 1-bit sigma-delta ADC modulators on the iCE40 readout board.
- Pipeline: three integrators at the input rate, then a decimation strobe, then three combs at the output rate, then saturation and truncation to the output width.

Parameters:
DEC_LOG2, 5, log2 of decimation ratio R (R = 2^DEC_LOG2 = 32); legal 2..8
OUT_WIDTH, 8, output sample width; legal 1..3*DEC_LOG2

Ports:
i_clk  input  1  system clock; all state changes on rising edge
i_rst  input  1  reset, asynchronous, active-high; clears all state
i_en  input  1  sample enable; an input bit is consumed only on cycles where i_en=1
i_sd  input  1  sigma-delta bitstream; 1 = +full-scale, 0 = zero
o_data  output  OUT_WIDTH  unsigned decimated sample; held between strobes
o_valid  output  1  one-cycle strobe; o_data is new on this cycle

Behaviour:
- Reset: i_clk single clock; i_rst asynchronous, active-high.
  - While i_rst=1: o_data=0, o_valid=0.
  - Integrators, combs, delay registers, decimation counter and warm-up counter are all 0.
  - Reset asserted mid-operation aborts any in-flight sample. No o_valid pulse is produced for it.
- Internal width: W = 3*DEC_LOG2+1 bits (16 at default).
  - All integrator and comb arithmetic is modulo 2^W; wrap-around is intended and must not saturate.
  - Input maps to a W-bit value of 0 or 1.
- Integrators: on each clock with i_en=1:
  - int1 <= int1 + i_sd
  - int2 <= int2 + int1
  - int3 <= int3 + int2
  - Each is a registered chain (old values on the right-hand side).
  - With i_en=0, all integrators and the decimation counter hold.
- Decimation counter: DEC_LOG2 bits, increments on every i_en=1 cycle and wraps R-1 -> 0.
  - Decimation strobe = (counter == R-1) AND i_en.
  - On the strobe edge, comb input x <= int3 (value before that edge's update).
- Comb stage 1 (clock after strobe):
  - c1 = x - x_d; c2 = c1 - c1_d; c3 = c2 - c2_d.
  - Each delay register updates only on this comb cycle.
- Comb stage 2 (following clock):
  - Saturate c3 to 2^(3*DEC_LOG2)-1. Full-scale R^3 overflows by one code; all-ones input must yield all-ones output.
  - o_data <= saturated[3*DEC_LOG2-1 -: OUT_WIDTH], i.e. truncate LSBs, no rounding.
  - o_valid=1 for exactly this one cycle.
- Comb pipeline advances on every clock regardless of i_en. Latency from strobe edge to o_valid = 2 clocks, fixed.
- Warm-up: a 2-bit counter suppresses o_valid (and the o_data update) for the first 2 strobes after reset.
  - First o_valid follows the 3rd strobe. The warm-up counter saturates at 2.
- Output rate: exactly one o_valid per R enabled cycles after warm-up. Minimum spacing R clocks; never back-to-back.
- Simultaneous i_en drop: if i_en falls right after a strobe, the comb pipeline still completes and o_valid still fires.
- Boundary DEC_LOG2 extremes: the counter wraps cleanly. OUT_WIDTH = 3*DEC_LOG2 gives full resolution.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then i_sd=0, i_en=1 continuous:
  - First o_valid exactly 3*32+2 = 98 clocks after reset release.
  - Subsequent strobes every 32 clocks.
  - o_data=0x00 throughout.
- i_sd=1 constant: from the 4th o_valid onward, o_data=0xFF. The saturation path must be hit (internal c3 = 32768 before clamp).
- i_sd alternating 1,0,1,0: from the 4th o_valid onward, o_data=0x80 exactly. The bench also checks internal c3=16384.
- i_en toggled 1,0 each clock with i_sd=1:
  - o_valid spacing is 64 clocks.
  - Steady o_data=0xFF.
  - Output values are identical to the i_en=1 run.
- Loopback mod2_dac (WIDTH 16) with i_data 0x00, 0x40, 0x80, 0xC0, each held 4000 clocks: settled o_data = 0x00, 0x40±1, 0x80±1, 0xC0±1 respectively.
- Assert i_rst for 1 clock mid-window (counter=17) during constant i_sd=1:
  - o_data=0 and o_valid=0 immediately (asynchronous).
  - No strobe for the aborted window.
  - Next o_valid occurs 98 clocks after release.
